bits_to_bytes_stream: RTL and testbench

- Streaming packer for the Kyber BitsToBytes operation: B[i/8] += b[i]·2^(i mod 8).
- Accepts a bit stream IN_W bits per beat over a valid/ready handshake.
- Packs the bits LSB-first into bytes and emits one byte per handshake, with a last flag and a done pulse.
- Sits between bit-serial sampling/compression logic and the byte-oriented encode/hash datapath.

---
 rtl/bits_to_bytes_stream_if.sv | 22 ++
 rtl/bits_to_bytes_stream.sv | 109 ++++++++++
 tb/tb_bits_to_bytes_stream.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bits_to_bytes_stream_if.sv
// Handshake bundle of the bits-to-bytes packer: bit stream in, byte stream out.
interface bits_to_bytes_stream_if #(
   parameter int IN_W = 1
) ();
   logic            bit_valid;
   logic [IN_W-1:0] bit_in;
   logic            bit_ready;
   logic            byte_valid;
   logic [7:0]      byte_out;
   logic            byte_last;
   logic            byte_ready;

   modport slave (
      input  bit_valid, bit_in, byte_ready,
      output bit_ready, byte_valid, byte_out, byte_last
   );

   modport master (
      output bit_valid, bit_in, byte_ready,
      input  bit_ready, byte_valid, byte_out, byte_last
   );
endinterface

// File: rtl/bits_to_bytes_stream.sv
// Kyber BitsToBytes packer: gathers IN_W-bit beats LSB-first into bytes and
// streams them out with a last flag, a busy level and a done pulse per frame.
module bits_to_bytes_stream #(
   parameter  int BYTE_COUNT = 256,
   parameter  int IN_W       = 1,
   localparam int LEN_W      = $clog2(BYTE_COUNT) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   bits_to_bytes_stream_if.slave stream
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [2:0]       LAST_CNT = 3'(8 - IN_W);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(BYTE_COUNT);

   state_t           state;
   logic [7:0]       acc;
   logic [2:0]       bit_cnt;
   logic [LEN_W-1:0] byte_idx;
   logic [LEN_W-1:0] len_q;

   logic             out_hs;
   logic             in_hs;
   logic             completing;
   logic             last_load;
   logic [7:0]       assembled;
   logic [LEN_W-1:0] len_clamped;

   assign out_hs           = stream.byte_valid && stream.byte_ready;
   // The completing beat may only enter when the output register is free or draining now.
   assign stream.bit_ready = (state == RUN) &&
                             !(bit_cnt == LAST_CNT && stream.byte_valid && !stream.byte_ready);
   assign in_hs            = stream.bit_valid && stream.bit_ready;
   assign completing       = in_hs && (bit_cnt == LAST_CNT);
   assign assembled        = acc | (8'(stream.bit_in) << bit_cnt);
   assign last_load        = (byte_idx + LEN_W'(1)) == len_q;
   assign len_clamped      = (len > MAX_LEN) ? MAX_LEN : len;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         acc               <= '0;
         bit_cnt           <= '0;
         byte_idx          <= '0;
         len_q             <= '0;
         stream.byte_valid <= 1'b0;
         stream.byte_out   <= '0;
         stream.byte_last  <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         done <= 1'b0;
         if (out_hs) begin
            stream.byte_valid <= 1'b0;
            stream.byte_last  <= 1'b0;
         end
         if (in_hs) begin
            if (completing) begin
               acc               <= '0;
               bit_cnt           <= '0;
               byte_idx          <= byte_idx + LEN_W'(1);
               stream.byte_valid <= 1'b1;
               stream.byte_out   <= assembled;
               stream.byte_last  <= last_load;
            end else begin
               acc     <= assembled;
               bit_cnt <= bit_cnt + 3'(IN_W);
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= len_clamped;
                  byte_idx <= '0;
                  acc      <= '0;
                  bit_cnt  <= '0;
                  busy     <= 1'b1;
                  // An empty frame passes through DRAIN, which finds no byte held.
                  state    <= (len_clamped == '0) ? DRAIN : RUN;
               end
            end
            RUN: begin
               if (completing && last_load) state <= DRAIN;
            end
            DRAIN: begin
               if (!stream.byte_valid || out_hs) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Self-checking bench for bits_to_bytes_stream: an IN_W=1 and an IN_W=8 instance,
// scoreboard queues filled at drive time and drained by negedge monitors.
module tb_bits_to_bytes_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start1 = 1'b0, start8 = 1'b0;
   logic [8:0] len1 = '0, len8 = '0;
   logic       busy1, done1, busy8, done8;

   int checks = 0, failures = 0, cyc = 0;
   logic [8:0] q1[$], q8[$];
   int hs_q1[$], acc_q1[$];
   int done_cnt1 = 0, done_cyc1 = -1, last_hs1 = -1, done_cnt8 = 0;
   int acc_cyc = 0, start_cyc1 = 0;
   bit br_seen1 = 1'b0, bv_seen1 = 1'b0, rnd8 = 1'b0;

   typedef struct {
      int          len;
      logic [31:0] data;
   } row_t;
   row_t rows[4];

   bits_to_bytes_stream_if #(.IN_W(1)) i1 ();
   bits_to_bytes_stream_if #(.IN_W(8)) i8 ();

   bits_to_bytes_stream #(.BYTE_COUNT(256), .IN_W(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .len(len1),
      .busy(busy1), .done(done1), .stream(i1)
   );

   bits_to_bytes_stream #(.BYTE_COUNT(256), .IN_W(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .len(len8),
      .busy(busy8), .done(done8), .stream(i8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (i1.bit_ready) br_seen1 = 1'b1;
      if (i1.byte_valid) bv_seen1 = 1'b1;
      if (done1) begin
         done_cnt1++;
         done_cyc1 = cyc;
      end
      if (i1.byte_valid && i1.byte_ready) begin
         hs_q1.push_back(cyc);
         last_hs1 = cyc;
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b1_unexpected actual=%0h required=none", {i1.byte_last, i1.byte_out});
         end else begin
            e = q1.pop_front();
            chk("b1_byte", 32'({i1.byte_last, i1.byte_out}), 32'(e));
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (done8) done_cnt8++;
      if (i8.byte_valid && i8.byte_ready) begin
         if (q8.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b8_unexpected actual=%0h required=none", {i8.byte_last, i8.byte_out});
         end else begin
            e = q8.pop_front();
            chk("b8_byte", 32'({i8.byte_last, i8.byte_out}), 32'(e));
         end
      end
   end

   task automatic chk_reset1(input string tag);
      chk({tag, "_bit_ready"}, 32'(i1.bit_ready), 0);
      chk({tag, "_byte_valid"}, 32'(i1.byte_valid), 0);
      chk({tag, "_byte_out"}, 32'(i1.byte_out), 0);
      chk({tag, "_byte_last"}, 32'(i1.byte_last), 0);
      chk({tag, "_busy"}, 32'(busy1), 0);
      chk({tag, "_done"}, 32'(done1), 0);
   endtask

   task automatic start_frame1(input int len);
      @(posedge clk); #1;
      start_cyc1 = cyc;
      start1 = 1'b1;
      len1 = 9'(len);
      @(posedge clk); #1;
      start1 = 1'b0;
   endtask

   task automatic put_bit(input logic b);
      int n;
      n = 0;
      i1.bit_valid = 1'b1;
      i1.bit_in = b;
      @(negedge clk);
      while (!i1.bit_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         failures++;
         $display("FAIL bit_accept_timeout actual=%0d required=<500", n);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
   endtask

   task automatic put_byte1(input logic [7:0] b);
      for (int k = 0; k < 8; k++) put_bit(b[k]);
      acc_q1.push_back(acc_cyc);
   endtask

   task automatic put_byte8(input logic [7:0] b);
      int n;
      n = 0;
      i8.bit_valid = 1'b1;
      i8.bit_in = b;
      @(negedge clk);
      while (!i8.bit_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         failures++;
         $display("FAIL byte8_accept_timeout actual=%0d required=<500", n);
      end
      @(posedge clk); #1;
      i8.bit_valid = 1'b0;
   endtask

   task automatic wait_done1(input int prev);
      int n;
      n = 0;
      while (done_cnt1 == prev && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         failures++;
         $display("FAIL done1_timeout actual=%0d required=<5000", n);
      end
   endtask

   task automatic run_row(input row_t r);
      int prev;
      logic [7:0] byt;
      prev = done_cnt1;
      hs_q1.delete();
      acc_q1.delete();
      start_frame1(r.len);
      for (int b = 0; b < r.len; b++) begin
         byt = r.data[8*b +: 8];
         q1.push_back({(b == r.len - 1), byt});
         put_byte1(byt);
      end
      i1.bit_valid = 1'b0;
      wait_done1(prev);
      chk("row_byte_count", hs_q1.size(), r.len);
      for (int b = 0; b < r.len && b < hs_q1.size(); b++)
         chk("row_byte_latency", hs_q1[b], acc_q1[b]);
      chk("row_done_timing", done_cyc1, last_hs1 + 1);
      @(negedge clk);
      chk("row_busy_after", 32'(busy1), 0);
      chk("row_sb_empty", q1.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int prev;
      logic [7:0] byt;
      logic [7:0] b1, b2, b3;

      rows[0] = '{len: 2, data: 32'h0000_3CA5};
      rows[1] = '{len: 1, data: 32'h0000_00FF};
      rows[2] = '{len: 4, data: 32'h1234_5678};
      rows[3] = '{len: 3, data: 32'h0000_FF81};

      i1.bit_valid = 1'b0; i1.bit_in = '0; i1.byte_ready = 1'b1;
      i8.bit_valid = 1'b0; i8.bit_in = '0; i8.byte_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset1("por");
      chk("por_busy8", 32'(busy8), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // table-driven frames with an always-ready sink
      for (int r = 0; r < 4; r++) run_row(rows[r]);

      // back-pressure: sink stalls after the first byte loads
      b1 = 8'h5A; b2 = 8'hC3; b3 = 8'h96;
      prev = done_cnt1;
      hs_q1.delete();
      i1.byte_ready = 1'b0;
      start_frame1(3);
      q1.push_back({1'b0, b1});
      q1.push_back({1'b0, b2});
      q1.push_back({1'b1, b3});
      for (int k = 0; k < 8; k++) put_bit(b1[k]);
      for (int k = 0; k < 7; k++) put_bit(b2[k]);
      i1.bit_valid = 1'b1;
      i1.bit_in = b2[7];
      repeat (3) begin
         @(negedge clk);
         chk("stall_bit_ready", 32'(i1.bit_ready), 0);
         chk("stall_byte_valid", 32'(i1.byte_valid), 1);
         chk("stall_byte_out", 32'(i1.byte_out), 32'(b1));
      end
      @(posedge clk); #1;
      i1.byte_ready = 1'b1;
      @(negedge clk);
      chk("release_bit_ready", 32'(i1.bit_ready), 1);
      @(posedge clk); #1;
      i1.bit_valid = 1'b0;
      for (int k = 0; k < 8; k++) put_bit(b3[k]);
      i1.bit_valid = 1'b0;
      wait_done1(prev);
      chk("stall_hs_count", hs_q1.size(), 3);
      if (hs_q1.size() >= 2) chk("stall_consecutive", hs_q1[1], hs_q1[0] + 1);
      chk("stall_sb_empty", q1.size(), 0);

      // zero-length frame
      prev = done_cnt1;
      br_seen1 = 1'b0;
      bv_seen1 = 1'b0;
      start_frame1(0);
      wait_done1(prev);
      chk("len0_done_timing", done_cyc1, start_cyc1 + 2);
      repeat (3) @(negedge clk);
      chk("len0_done_count", done_cnt1, prev + 1);
      chk("len0_bit_ready_seen", 32'(br_seen1), 0);
      chk("len0_byte_valid_seen", 32'(bv_seen1), 0);

      // reset in the middle of a frame, 13 bits in
      start_frame1(4);
      q1.push_back({1'b0, 8'hB7});
      put_byte1(8'hB7);
      for (int k = 0; k < 5; k++) put_bit(1'b1);
      i1.bit_valid = 1'b0;
      prev = done_cnt1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset1("mid_reset");
      chk("mid_reset_sb_empty", q1.size(), 0);
      repeat (3) @(negedge clk);
      chk("mid_reset_no_done", done_cnt1, prev);
      run_row(rows[1]);

      // start pulsed during RUN is ignored
      prev = done_cnt1;
      hs_q1.delete();
      start_frame1(2);
      q1.push_back({1'b0, 8'h11});
      q1.push_back({1'b1, 8'h22});
      byt = 8'h11;
      for (int k = 0; k < 3; k++) put_bit(byt[k]);
      start1 = 1'b1;
      len1 = 9'd1;
      put_bit(byt[3]);
      start1 = 1'b0;
      for (int k = 4; k < 8; k++) put_bit(byt[k]);
      byt = 8'h22;
      for (int k = 0; k < 8; k++) put_bit(byt[k]);
      i1.bit_valid = 1'b0;
      wait_done1(prev);
      chk("restart_hs_count", hs_q1.size(), 2);
      chk("restart_sb_empty", q1.size(), 0);

      // oversize length clamps to BYTE_COUNT
      prev = done_cnt1;
      hs_q1.delete();
      start_frame1(300);
      for (int b = 0; b < 256; b++) begin
         byt = 8'($urandom_range(0, 255));
         q1.push_back({(b == 255), byt});
         for (int k = 0; k < 8; k++) put_bit(byt[k]);
      end
      i1.bit_valid = 1'b0;
      wait_done1(prev);
      repeat (3) @(negedge clk);
      chk("clamp_hs_count", hs_q1.size(), 256);
      chk("clamp_done_count", done_cnt1, prev + 1);
      chk("clamp_sb_empty", q1.size(), 0);

      // IN_W=8 full frame with random source and sink gaps
      prev = done_cnt8;
      rnd8 = 1'b1;
      fork
         begin
            while (rnd8) begin
               @(posedge clk); #1;
               i8.byte_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      @(posedge clk); #1;
      start8 = 1'b1;
      len8 = 9'd256;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int b = 0; b < 256; b++) begin
         byt = 8'($urandom_range(0, 255));
         q8.push_back({(b == 255), byt});
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         put_byte8(byt);
      end
      begin
         int n;
         n = 0;
         while (done_cnt8 == prev && n < 5000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL done8_timeout actual=%0d required=<5000", n);
         end
      end
      rnd8 = 1'b0;
      repeat (4) @(negedge clk);
      i8.byte_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("w8_done_count", done_cnt8, prev + 1);
      chk("w8_sb_empty", q8.size(), 0);
      chk("w8_busy_after", 32'(busy8), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
